// File: rtl/coin_dispense.sv
// coin_dispense: greedy change dispenser handing dimes/nickels to a hopper; `COIN_DISPENSE_QUARTER_EN adds quarters
module coin_dispense #(
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  output logic [1:0]       coin,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nx;
  logic [AMT_W-1:0] remaining, remaining_nx, coin_val;
  logic [1:0] greedy;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nx;
      remaining <= remaining_nx;
    end
  always_comb begin
`ifdef COIN_DISPENSE_QUARTER_EN
    greedy = remaining >= AMT_W'(5) ? 2'b11 : remaining >= AMT_W'(2) ? 2'b10 : 2'b01;
`else
    greedy = remaining >= AMT_W'(2) ? 2'b10 : 2'b01;
`endif
    coin_val = greedy == 2'b11 ? AMT_W'(5) : greedy == 2'b10 ? AMT_W'(2) : AMT_W'(1);
    state_nx = state;
    remaining_nx = remaining;
    if (state == IDLE && req) begin
      remaining_nx = amount;
      state_nx = amount == '0 ? DONE : ISSUE;
    end else if (state == ISSUE && coin_ack) begin
      remaining_nx = remaining - coin_val;
      state_nx = remaining_nx == '0 ? DONE : ISSUE;
    end else if (state == DONE)
      state_nx = IDLE;
  end
  always_comb begin
    coin_valid = state == ISSUE;
    coin = coin_valid ? greedy : 2'b00;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_coin_dispense.sv
// tb_coin_dispense: directed vectors with a scoreboard of expected coin/done events checked by a monitor
module tb_coin_dispense;
  localparam int EV_DONE = 4;
  logic clock = 0, reset = 0, req = 0, coin_ack = 0;
  logic [3:0] amount = '0;
  logic [1:0] coin;
  logic coin_valid, busy, done;
  int checks = 0, errors = 0;
  int exp_q[$];

  coin_dispense #(.AMT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .amount(amount), .coin(coin),
    .coin_valid(coin_valid), .coin_ack(coin_ack), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clock) if (reset) begin
    if (coin_valid && coin_ack) begin
      if (exp_q.size() == 0) check("unexpected_coin", int'(coin), -1);
      else check("coin", int'(coin), exp_q.pop_front());
    end
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, -1);
      else begin
        check("done_event", EV_DONE, exp_q.pop_front());
        check("done_no_coin", int'(coin_valid), 0);
      end
    end
    if (!coin_valid) check("coin_idle_zero", int'(coin), 0);
  end

  task automatic start(input logic [3:0] amt);
    @(posedge clock) #1;
    req = 1;
    amount = amt;
    @(posedge clock) #1;
    req = 0;
    amount = 4'hf;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clock) #1;
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  initial begin
    #2;
    check("rst_valid", int'(coin_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_coin", int'(coin), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;

    // first edge after release accepts req
    coin_ack = 1;
    exp_q.push_back(1); exp_q.push_back(EV_DONE);
    start(1);
    wait_idle("amt1_cycles", 2);

    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(EV_DONE);
    start(3);
    check("amt3_first_valid", int'(coin_valid), 1);
    wait_idle("amt3_cycles", 3);

    exp_q.push_back(EV_DONE);
    start(0);
    check("amt0_busy", int'(busy), 1);
    check("amt0_done", int'(done), 1);
    check("amt0_valid", int'(coin_valid), 0);
    wait_idle("amt0_cycles", 1);

    coin_ack = 0;
    exp_q.push_back(2); exp_q.push_back(EV_DONE);
    start(2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(coin_valid), 1);
      check("stall_coin", int'(coin), 2);
      @(posedge clock) #1;
    end
    check("stall_valid6", int'(coin_valid), 1);
    check("stall_coin6", int'(coin), 2);
    coin_ack = 1;
    wait_idle("stall_cycles", 2);

    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(EV_DONE);
    start(4);
    req = 1;
    amount = 7;
    @(posedge clock) #1;
    req = 0;
    wait_idle("ignore_req_cycles", 2);
    repeat (3) @(posedge clock);

`ifdef COIN_DISPENSE_QUARTER_EN
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(EV_DONE);
    start(7);
    wait_idle("amt7_cycles", 3);
`else
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(EV_DONE);
    start(7);
    wait_idle("amt7_cycles", 5);
`endif

    // reset mid-ISSUE between edges, no transfers since ack is low
    coin_ack = 0;
    start(5);
    @(posedge clock) #3;
    check("pre_rst_valid", int'(coin_valid), 1);
    reset = 0;
    #1;
    check("mid_rst_valid", int'(coin_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_coin", int'(coin), 0);
    @(posedge clock) #1;
    reset = 1;
    coin_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock) #1;
      check("post_rst_done", int'(done), 0);
      check("post_rst_busy", int'(busy), 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
